// File: rtl/m003_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first through one full-subtractor cell.
// Operands in and result out each use a valid/ready handshake.
module m003_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              bit_d;
    logic              br_next;

    // Single full-subtractor cell working on the operand LSBs.
    assign bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                sh_d  = WIDTH'({bit_d, sh_q} >> 1);
                cnt_d = cnt_q + CntW'(1);
                // Output registers only change on completion so diff_o/bout_o stay
                // at the previous result while shifting.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    diff_d  = sh_d;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle) & rst_ni;
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StShift);
    assign diff_o      = diff_q;
    assign bout_o      = bout_q;

endmodule

// File: tb/tb_m003_serial_subtractor.sv
// Directed self-checking bench for m003_serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_m003_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, busy8;
    logic [7:0] a8, b8, diff8;

    logic       in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1, busy1;
    logic [0:0] a1, b1, diff1;

    int n_checks;
    int n_fail;

    m003_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .a_i         (a8),
        .b_i         (b8),
        .bin_i       (bin8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .diff_o      (diff8),
        .bout_o      (bout8),
        .busy_o      (busy8)
    );

    m003_serial_subtractor #(.WIDTH(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .a_i         (a1),
        .b_i         (b1),
        .bin_i       (bin1),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .diff_o      (diff1),
        .bout_o      (bout1),
        .busy_o      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the WIDTH=8 instance and wait (bounded) for out_valid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input bit scramble, output logic [7:0] d, output logic bo,
                        output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        in_valid8 = 1'b1;
        a8 = a;
        b8 = b;
        bin8 = bin;
        step();
        in_valid8 = 1'b0;
        while (out_valid8 !== 1'b1 && lat < 50) begin
            if (busy8 === 1'b1) busy_cycles++;
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                bin8 = 1'($urandom);
            end
            step();
            lat++;
        end
        d = diff8;
        bo = bout8;
    endtask

    task automatic handshake8();
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || busy8 !== 1'b0 ||
            diff8 !== 8'h00 || bout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b diff=%h bout=%b, want 0 0 0 00 0",
                     in_ready8, out_valid8, busy8, diff8, bout8);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready8 !== 1'b1 || in_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: rdy8=%b rdy1=%b, want 1 1", in_ready8, in_ready1);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        run8(8'h3C, 8'h1A, 1'b0, 1'b0, d, bo, lat, bc);
        n_checks++;
        if (d !== 8'h22 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: diff=%h bout=%b, want 22 0", d, bo);
        end
        n_checks++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL basic_latency: %0d edges, want 8", lat);
        end
        n_checks++;
        if (bc != 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: %0d, want 8", bc);
        end
        n_checks++;
        if (in_ready8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_flags: rdy=%b busy=%b, want 0 0", in_ready8, busy8);
        end
        handshake8();
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || diff8 !== 8'h22) begin
            n_fail++;
            $display("FAIL basic_after_handshake: vld=%b rdy=%b diff=%h, want 0 1 22",
                     out_valid8, in_ready8, diff8);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] va [3] = '{8'h00, 8'h55, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'h55, 8'h7F};
        logic       vi [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] ed [3] = '{8'hFF, 8'hFF, 8'h01};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] d;
        logic bo;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], vi[i], 1'b0, d, bo, lat, bc);
            n_checks++;
            if (d !== ed[i] || bo !== eb[i] || lat != 8) begin
                n_fail++;
                $display("FAIL borrow_vec%0d: diff=%h bout=%b lat=%0d, want %h %b 8",
                         i, d, bo, lat, ed[i], eb[i]);
            end
            handshake8();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        run8(8'hA5, 8'h5A, 1'b0, 1'b0, d, bo, lat, bc);
        n_checks++;
        if (d !== 8'h4B || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: diff=%h bout=%b, want 4b 0", d, bo);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'h11;
            b8 = 8'h22;
            bin8 = 1'b1;
            step();
            n_checks++;
            if (out_valid8 !== 1'b1 || diff8 !== 8'h4B || bout8 !== 1'b0 ||
                in_ready8 !== 1'b0 || busy8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b diff=%h bout=%b rdy=%b busy=%b, want 1 4b 0 0 0",
                         i, out_valid8, diff8, bout8, in_ready8, busy8);
            end
        end
        in_valid8 = 1'b0;
        handshake8();
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b, want 0 1 0",
                     out_valid8, in_ready8, busy8);
        end
        step();
        n_checks++;
        if (busy8 !== 1'b0 || out_valid8 !== 1'b0 || diff8 !== 8'h4B) begin
            n_fail++;
            $display("FAIL bp_no_accept: busy=%b vld=%b diff=%h, want 0 0 4b",
                     busy8, out_valid8, diff8);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        in_valid8 = 1'b1;
        a8 = 8'h3C;
        b8 = 8'h1A;
        bin8 = 1'b0;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_shift: busy=%b, want 1", busy8);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (out_valid8 !== 1'b0 || diff8 !== 8'h00 || busy8 !== 1'b0 || bout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: vld=%b diff=%h busy=%b bout=%b, want 0 00 0 0",
                     out_valid8, diff8, busy8, bout8);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: rdy=%b vld=%b, want 1 0", in_ready8, out_valid8);
        end
        run8(8'h10, 8'h01, 1'b0, 1'b0, d, bo, lat, bc);
        n_checks++;
        if (d !== 8'h0F || bo !== 1'b0 || lat != 8) begin
            n_fail++;
            $display("FAIL rstmid_next_op: diff=%h bout=%b lat=%0d, want 0f 0 8", d, bo, lat);
        end
        handshake8();
    endtask

    task automatic test_operand_change();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        // 0xC3 - 0x3D - 1 = 195 - 61 - 1 = 133 = 0x85
        run8(8'hC3, 8'h3D, 1'b1, 1'b1, d, bo, lat, bc);
        n_checks++;
        if (d !== 8'h85 || bo !== 1'b0 || lat != 8) begin
            n_fail++;
            $display("FAIL opchange_result: diff=%h bout=%b lat=%0d, want 85 0 8", d, bo, lat);
        end
        handshake8();
    endtask

    task automatic test_width1();
        for (int i = 0; i < 8; i++) begin
            int v;
            logic ed, eb;
            v  = ((i >> 2) & 1) - ((i >> 1) & 1) - (i & 1);
            ed = (v & 1) != 0;
            eb = v < 0;
            in_valid1 = 1'b1;
            a1 = 1'((i >> 2) & 1);
            b1 = 1'((i >> 1) & 1);
            bin1 = 1'(i & 1);
            step();
            in_valid1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1) begin
                n_fail++;
                $display("FAIL w1_busy%0d: busy=%b, want 1", i, busy1);
            end
            step();
            n_checks++;
            if (out_valid1 !== 1'b1 || diff1 !== ed || bout1 !== eb) begin
                n_fail++;
                $display("FAIL w1_combo%0d: vld=%b diff=%b bout=%b, want 1 %b %b",
                         i, out_valid1, diff1, bout1, ed, eb);
            end
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
            n_checks++;
            if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_return%0d: rdy=%b vld=%b, want 1 0", i, in_ready1, out_valid1);
            end
        end
    endtask

    // in_ready and out_valid must never overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if ((in_ready8 & out_valid8) === 1'b1 || (in_ready1 & out_valid1) === 1'b1) begin
                n_fail++;
                $display("FAIL ready_valid_overlap: rdy8=%b vld8=%b rdy1=%b vld1=%b, want no overlap",
                         in_ready8, out_valid8, in_ready1, out_valid1);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0;
        a8 = '0;
        b8 = '0;
        bin8 = 1'b0;
        out_ready8 = 1'b0;
        in_valid1 = 1'b0;
        a1 = '0;
        b1 = '0;
        bin1 = 1'b0;
        out_ready1 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_reset_mid();
        test_operand_change();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m003_serial_subtractor.md
# m003_serial_subtractor

Bit-serial subtractor computing diff = a − b − bin over WIDTH-bit operands. It sits beside the combinational full-adder datapath as its inverse-direction arithmetic unit. Operands are accepted through a valid/ready handshake and processed LSB-first through a single 1-bit full-subtractor cell, one bit per clock. The result and borrow-out are presented through an output valid/ready handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 1
- clk_i  input  1  single clock; all state changes on the rising edge
- rst_ni  input  1  reset, synchronous, active-low
- in_valid_i  input  1  operands a_i/b_i/bin_i valid
- in_ready_o  output  1  block can accept operands (IDLE only)
- a_i  input  WIDTH  minuend
- b_i  input  WIDTH  subtrahend
- bin_i  input  1  borrow-in
- out_valid_o  output  1  diff_o/bout_o valid
- out_ready_i  input  1  consumer accepts result
- diff_o  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout_o  output  1  final borrow: 1 iff a < b + bin (unsigned)
- busy_o  output  1  high in SHIFT state

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready_o = 1. On an edge with in_valid_i & in_ready_o, latch a_i, b_i into shift registers, load bin_i into the borrow flop, clear the bit counter, and go to SHIFT.
- SHIFT: each cycle, take the LSBs a, b and borrow br; d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br). Shift d into the result register from the MSB side; shift the operands right; increment the counter. After the WIDTH-th bit, go to DONE.
- DONE: out_valid_o = 1. diff_o and bout_o hold stable. On an edge with out_valid_o & out_ready_i, go to IDLE.
- Inputs a_i, b_i, bin_i and in_valid_i are ignored outside IDLE. Operand changes after acceptance have no effect.
- diff_o and bout_o keep their last result in IDLE until the next result overwrites them.
- The counter is sized to hold WIDTH. WIDTH = 1 must work (a single SHIFT cycle).
- No arithmetic exception: underflow is reported only via bout_o.

## Timing
- Reset: on an edge with rst_ni = 0, the state goes to IDLE and diff_o = 0, bout_o = 0, out_valid_o = 0, busy_o = 0. in_ready_o = (state == IDLE) & rst_ni, so it is 0 while rst_ni is low and 1 in the cycle after the reset edge.
- Reset mid-SHIFT or mid-DONE aborts the operation. out_valid_o never asserts for the aborted operands, and the result is cleared.
- Latency: accept edge at T. SHIFT covers cycles T+1 .. T+WIDTH. out_valid_o is high from the edge at T+WIDTH onward (first visible in cycle T+WIDTH+1 after the accept cycle).
- Output handshake edge at U: out_valid_o = 0 and in_ready_o = 1 in cycle U+1. The next accept is earliest at edge U+1.
- Throughput: one operation per WIDTH+2 cycles minimum.
- in_ready_o and out_valid_o are never high in the same cycle.
- Back-pressure: out_ready_i low holds DONE indefinitely with outputs stable.

## Test plan
- WIDTH=8; a=0x3C, b=0x1A, bin=0 -> diff_o=0x22, bout_o=0. out_valid_o rises exactly 8 edges after the accept edge; busy_o is high for exactly 8 cycles.
- WIDTH=8; a=0x00, b=0x01, bin=0 -> diff_o=0xFF, bout_o=1. Also a=0x55, b=0x55, bin=1 -> diff_o=0xFF, bout_o=1. Also a=0x80, b=0x7F, bin=0 -> diff_o=0x01, bout_o=0.
- Back-pressure: hold out_ready_i=0 for 5 cycles in DONE while driving in_valid_i=1 with new operands -> out_valid_o stays 1, diff_o is unchanged, in_ready_o=0, and the new operands are not accepted. Raising out_ready_i then causes one handshake, and in_ready_o=1 the next cycle.
- Reset mid-operation: assert rst_ni=0 on the 4th SHIFT cycle -> the next cycle has out_valid_o=0, diff_o=0, busy_o=0. After release, in_ready_o=1, and a following 0x10−0x01 operation yields 0x0F, bout_o=0.
- Operand change after accept: drive a_i/b_i to random values during SHIFT -> the result matches the latched operands only.
- WIDTH=1, exhaustive: all 8 {a, b, bin} combos -> diff_o and bout_o match the full-subtractor truth table; out_valid_o is high 1 edge after accept.
